// File: rtl/uart_inst_loader.sv
// 8N1 UART receiver that packs four bytes (big-endian) into a 32-bit word
// and writes it to instruction memory at an auto-incrementing word address.
module uart_inst_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        en,
    output logic        we,
    output logic [7:0]  addr,
    output logic [31:0] wdata,
    output logic [7:0]  rx_byte,
    output logic        busy,
    output logic        frame_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic            en_q;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [1:0]      byte_idx;
    logic [7:0]      shift;

    // rx is asynchronous to clk; the line idles high, so the flops reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // we is a one-cycle strobe with no back-pressure: the memory must take
    // addr/wdata in the cycle we is high; addr advances in the cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en_q      <= 1'b0;
            timer     <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            en_q <= en;
            we   <= 1'b0;

            if (en && !en_q) begin
                frame_err <= 1'b0;
            end

            if (we) begin
                addr     <= addr + 8'd1;
                byte_idx <= '0;
            end

            if (!en) begin
                // Abort wins over everything, including a pending address step.
                state    <= IDLE;
                timer    <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
                addr     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            timer <= '0;
                        end
                    end

                    START: begin
                        if (timer == HALF) begin
                            timer <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    DATA: begin
                        if (timer == LAST) begin
                            timer <= '0;
                            shift <= {rx_s, shift[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    STOP: begin
                        if (timer == LAST) begin
                            timer <= '0;
                            state <= IDLE;
                            if (rx_s) begin
                                rx_byte <= shift;
                                case (byte_idx)
                                    2'd0:    wdata[31:24] <= shift;
                                    2'd1:    wdata[23:16] <= shift;
                                    2'd2:    wdata[15:8]  <= shift;
                                    default: wdata[7:0]   <= shift;
                                endcase
                                // The last byte holds byte_idx at 3 until the strobe retires it.
                                if (byte_idx == 2'd3) begin
                                    we <= 1'b1;
                                end else begin
                                    byte_idx <= byte_idx + 2'd1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                byte_idx  <= '0;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE) || (byte_idx != 2'd0);

endmodule
